// File: rtl/in_shift_ctrl.sv
// Sequencer for one PE row's input feature shift register: fills N taps, then sweeps
// the tap select oldest->newest for every sliding window of a row of num_cols features.
module in_shift_ctrl #(
  parameter int N         = 3,
  parameter int I_WIDTH   = 8,
  parameter int SEL_WIDTH = $clog2(N),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_cols_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [I_WIDTH-1:0]   in_feature_i,
  output logic [I_WIDTH-1:0]   feature_o,
  output logic                 freg_rst_o,
  output logic                 freg_ld_o,
  output logic [SEL_WIDTH-1:0] f_sel_o,
  output logic                 sel_valid_o,
  input  logic                 sel_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, SWEEP, SLIDE, DONE} state_t;

  localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(N - 1);
  localparam logic [CNT_WIDTH-1:0] N_CNT   = CNT_WIDTH'(N);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   num_cols_q;
  logic [CNT_WIDTH-1:0]   loaded;
  logic [CNT_WIDTH-1:0]   loaded_inc;
  logic                   in_ready_q;
  logic                   sel_valid_q;
  logic [SEL_WIDTH-1:0]   f_sel_q;
  logic                   clr_q;
  logic                   done_q;
  logic                   err_q;
  logic                   ld;

  assign ld         = in_valid_i & in_ready_q;
  assign loaded_inc = (loaded == '1) ? loaded : loaded + CNT_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      num_cols_q  <= '0;
      loaded      <= '0;
      in_ready_q  <= 1'b0;
      sel_valid_q <= 1'b0;
      f_sel_q     <= '0;
      clr_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (num_cols_i >= N_CNT) begin
              num_cols_q <= num_cols_i;
              loaded     <= '0;
              clr_q      <= 1'b1;
              state      <= CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          in_ready_q <= 1'b1;
          state      <= FILL;
        end
        FILL: begin
          if (ld) begin
            loaded <= loaded_inc;
            if (loaded_inc == N_CNT) begin
              in_ready_q  <= 1'b0;
              sel_valid_q <= 1'b1;
              f_sel_q     <= SEL_MAX;
              state       <= SWEEP;
            end
          end
        end
        SWEEP: begin
          if (sel_ready_i) begin
            if (f_sel_q == '0) begin
              // Last tap of the window: either the row is exhausted or one more feature slides in.
              sel_valid_q <= 1'b0;
              if (loaded == num_cols_q) begin
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                in_ready_q <= 1'b1;
                state      <= SLIDE;
              end
            end else begin
              f_sel_q <= f_sel_q - SEL_WIDTH'(1);
            end
          end
        end
        SLIDE: begin
          if (ld) begin
            loaded      <= loaded_inc;
            in_ready_q  <= 1'b0;
            sel_valid_q <= 1'b1;
            f_sel_q     <= SEL_MAX;
            state       <= SWEEP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign sel_valid_o = sel_valid_q;
  assign f_sel_o     = f_sel_q;
  assign feature_o   = in_feature_i;
  assign freg_ld_o   = ld;
  assign freg_rst_o  = ~rst_n_i | clr_q;
  assign busy_o      = (state != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_in_shift_ctrl.sv
// Directed bench for in_shift_ctrl: cycle trace, windowed data through a shift-register
// model, stall handling, rejected start, mid-row reset and a full-length row on a narrow counter.
module tb_in_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_cols;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_feature;
  logic [7:0]  feature;
  logic        freg_rst, freg_ld;
  logic [1:0]  f_sel;
  logic        sel_valid, sel_ready;
  logic        busy, done, err;

  logic        w_start;
  logic [7:0]  w_num_cols;
  logic        w_one = 1'b1;
  logic        w_in_ready, w_freg_rst, w_freg_ld, w_sel_valid, w_busy, w_done, w_err;
  logic [7:0]  w_feature;
  logic [1:0]  w_f_sel;

  int errors = 0;
  int checks = 0;

  int hs_cnt, ld_cnt, done_cnt, viol;
  logic [1:0] tap_log[$];
  logic [7:0] data_log[$];

  always #5 clk = ~clk;

  in_shift_ctrl #(.N(3), .I_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .num_cols_i(num_cols),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_feature_i(in_feature),
    .feature_o(feature), .freg_rst_o(freg_rst), .freg_ld_o(freg_ld),
    .f_sel_o(f_sel), .sel_valid_o(sel_valid), .sel_ready_i(sel_ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  in_shift_ctrl #(.N(3), .I_WIDTH(8), .CNT_WIDTH(8)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(w_start), .num_cols_i(w_num_cols),
    .in_valid_i(w_one), .in_ready_o(w_in_ready), .in_feature_i(in_feature),
    .feature_o(w_feature), .freg_rst_o(w_freg_rst), .freg_ld_o(w_freg_ld),
    .f_sel_o(w_f_sel), .sel_valid_o(w_sel_valid), .sel_ready_i(w_one),
    .busy_o(w_busy), .done_o(w_done), .err_o(w_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, in_ready, sel_valid, f_sel[1:0], done, err, freg_rst}
  function automatic logic [7:0] reset_view();
    return {busy, in_ready, sel_valid, f_sel, done, err, freg_rst};
  endfunction

  // Runs one row with a behavioural in_shift_reg (tap 0 newest) and logs every tap handshake.
  task automatic run_row(input int nc, input bit gaps, input bit hold_start, input int budget);
    logic [7:0] sr [3];
    int   idx;
    bit   fin, stall_prev;
    logic [1:0] sel_prev;
    logic s_rst, s_ld, s_hs;
    logic [1:0] s_sel;
    foreach (sr[i]) sr[i] = '0;
    hs_cnt = 0; ld_cnt = 0; done_cnt = 0; viol = 0;
    tap_log.delete(); data_log.delete();
    idx = 0; fin = 0; stall_prev = 0; sel_prev = '0;
    start = 1'b1;
    num_cols = 16'(nc);
    for (int c = 0; c < budget && !fin; c++) begin
      in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      sel_ready  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_feature = 8'((idx + 1) * 10);
      #1;
      if (stall_prev && !(sel_valid && f_sel == sel_prev)) viol++;
      if (freg_ld && (freg_rst || !busy || sel_valid)) viol++;
      if (feature !== in_feature) viol++;
      s_rst = freg_rst;
      s_ld  = freg_ld;
      s_sel = f_sel;
      s_hs  = sel_valid & sel_ready;
      if (s_hs) begin
        hs_cnt++;
        tap_log.push_back(s_sel);
        data_log.push_back(sr[s_sel]);
      end
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      stall_prev = sel_valid & ~sel_ready;
      sel_prev   = s_sel;
      tick();
      if (hold_start) num_cols = 16'd3;
      else start = 1'b0;
      if (s_rst) begin
        foreach (sr[i]) sr[i] = '0;
      end else if (s_ld) begin
        sr[2] = sr[1];
        sr[1] = sr[0];
        sr[0] = in_feature;
        idx++;
        ld_cnt++;
      end
    end
    start = 1'b0;
    if (!fin) check("row_timeout", 32'd0, 32'd1);
  endtask

  // Window w, handshake j presents tap 2-j holding feature 10*(w+j+1).
  task automatic check_windows(input string tag);
    for (int h = 0; h < tap_log.size(); h++) begin
      check({tag, "_tap"}, 32'(tap_log[h]), 32'(2 - (h % 3)));
      check({tag, "_data"}, 32'(data_log[h]), 32'(10 * ((h / 3) + (h % 3) + 1)));
    end
  endtask

  logic [6:0] trace_exp [13] = '{
    7'b1000100, 7'b0100100, 7'b0100100, 7'b0100100,
    7'b0010110, 7'b0010101, 7'b0010100, 7'b0100100,
    7'b0010110, 7'b0010101, 7'b0010100, 7'b0001100,
    7'b0000000
  };

  initial begin
    int wh, wl, dseen;
    bit wfin;
    rst_n = 1'b0; start = 1'b0; num_cols = '0; in_valid = 1'b0; sel_ready = 1'b0;
    in_feature = '0; w_start = 1'b0; w_num_cols = '0;
    repeat (2) tick();
    check("reset_outputs", 32'(reset_view()), 32'h01);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'(reset_view()), 32'h00);

    // Cycle trace, num_cols=4, valid/ready tied high, start at c0.
    in_valid = 1'b1; sel_ready = 1'b1; start = 1'b1; num_cols = 16'd4;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
      check($sformatf("trace_c%0d", c),
            32'({freg_rst, freg_ld, sel_valid, done, busy, sel_valid ? f_sel : 2'b00}),
            32'(trace_exp[c-1]));
    end

    // Feature stream 10,20,30,40 -> windows (10,20,30), (20,30,40).
    run_row(4, 1'b0, 1'b0, 100);
    check("stream_handshakes", 32'(hs_cnt), 32'd6);
    check("stream_loads", 32'(ld_cnt), 32'd4);
    check("stream_invariants", 32'(viol), 32'd0);
    check_windows("stream");

    // Random gaps plus start held high throughout (ignored while busy).
    run_row(5, 1'b1, 1'b1, 400);
    check("gaps_handshakes", 32'(hs_cnt), 32'd9);
    check("gaps_loads", 32'(ld_cnt), 32'd5);
    check("gaps_hold_invariants", 32'(viol), 32'd0);
    check("gaps_done", 32'(done_cnt), 32'd1);
    check_windows("gaps");
    tick();
    check("gaps_idle_after", 32'(busy), 32'd0);

    // Rejected start: num_cols < N.
    in_valid = 1'b1; start = 1'b1; num_cols = 16'd2;
    tick();
    start = 1'b0;
    check("err_pulse", 32'({err, busy, freg_rst, freg_ld}), 32'b1000);
    tick();
    check("err_clears", 32'({err, busy, freg_rst, freg_ld}), 32'b0000);

    // num_cols == N: a single window.
    run_row(3, 1'b0, 1'b0, 100);
    check("min_row_handshakes", 32'(hs_cnt), 32'd3);
    check("min_row_done", 32'(done_cnt), 32'd1);
    check_windows("min_row");

    // Reset during the second sweep.
    in_valid = 1'b1; sel_ready = 1'b1; start = 1'b1; num_cols = 16'd4;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_sweep2", 32'({sel_valid, f_sel}), 32'b110);
    rst_n = 1'b0;
    #1;
    check("mid_row_reset", 32'(reset_view()), 32'h01);
    dseen = 0;
    repeat (3) begin
      tick();
      if (done) dseen++;
    end
    rst_n = 1'b1;
    tick();
    if (done) dseen++;
    check("no_done_after_abort", 32'(dseen), 32'd0);
    run_row(4, 1'b0, 1'b0, 100);
    check("post_reset_handshakes", 32'(hs_cnt), 32'd6);
    check("post_reset_done", 32'(done_cnt), 32'd1);

    // Full-scale row on an 8-bit counter: num_cols=255 -> 253 windows.
    wh = 0; wl = 0; wfin = 0;
    w_start = 1'b1; w_num_cols = 8'd255;
    for (int c = 0; c < 2000 && !wfin; c++) begin
      tick();
      w_start = 1'b0;
      if (w_sel_valid) wh++;
      if (w_freg_ld) wl++;
      if (w_done) wfin = 1;
    end
    check("max_row_done", 32'(wfin), 32'd1);
    check("max_row_handshakes", 32'(wh), 32'd759);
    check("max_row_loads", 32'(wl), 32'd255);
    tick();
    check("max_row_idle", 32'({w_busy, w_err}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
